axi_lite_fifo_slave: RTL and testbench

AXI4-Lite slave front-end that owns a synchronous data FIFO and exposes it as three memory-mapped registers (DATA, STATUS, CTRL). It sits directly downstream of the system AXI-Lite master and consumes its AW/W/AR channels. It produces the B/R channels using the shared AXI-Lite package types (addr_t, data_t, strb_t, prot_t, resp_t) and response codes (RESP_OKAY, RESP_SLVERR, RESP_DECERR). One write and one read transaction may be outstanding at a time. The two paths are independent.

---
 rtl/axi_lite_fifo_slave.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_fifo_slave.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_fifo_slave.sv
// AXI4-Lite slave exposing a synchronous data FIFO as three registers.
//
//   addr[3:2] = 0 : DATA   - write pushes wdata, read pops the head
//   addr[3:2] = 1 : STATUS - [0] empty, [1] full, [16 +: CNT_W] count
//   addr[3:2] = 2 : CTRL   - write with wdata[0]=1 (and wstrb[0]) flushes
//   addr[3:2] = 3 : unmapped (DECERR)
//
// Ports: clk / rst_n (async, active low); AW, W, B channels for writes;
// AR, R channels for reads. The write and read paths are independent and
// each allows one outstanding transaction.
package axi_lite_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [2:0]  prot_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;
endpackage

module axi_lite_fifo_slave
  import axi_lite_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  addr_t awaddr,
  input  prot_t awprot,
  input  logic  awvalid,
  output logic  awready,
  input  data_t wdata,
  input  strb_t wstrb,
  input  logic  wvalid,
  output logic  wready,
  output resp_t bresp,
  output logic  bvalid,
  input  logic  bready,
  input  addr_t araddr,
  input  prot_t arprot,
  input  logic  arvalid,
  output logic  arready,
  output data_t rdata,
  output resp_t rresp,
  output logic  rvalid,
  input  logic  rready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] SEL_DATA   = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;

  // holding registers
  logic       aw_held, w_held, ar_held;
  logic [1:0] aw_sel, ar_sel;
  data_t      w_data;
  strb_t      w_strb;

  // fifo state
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  data_t            mem [DEPTH];

  logic  empty, full;
  logic  wr_exec, rd_exec;
  logic  do_push, do_pop, do_flush;
  data_t status;
  resp_t wr_resp, rd_resp;
  data_t rd_data;

  // Only addr[3:2] is decoded; the rest of the address and prot are don't-care.
  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr[31:4], awaddr[1:0],
                       araddr[31:4], araddr[1:0]};

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held  && !bvalid;
  assign arready = !ar_held && !rvalid;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign wr_exec = aw_held && w_held;
  assign rd_exec = ar_held;

  // Full/empty come from the pre-edge state, so a same-edge pop never makes
  // room for a push (and vice versa).
  assign do_push  = wr_exec && (aw_sel == SEL_DATA) && (w_strb == 4'hF) && !full;
  assign do_pop   = rd_exec && (ar_sel == SEL_DATA) && !empty;
  assign do_flush = wr_exec && (aw_sel == SEL_CTRL) && w_data[0] && w_strb[0];

  always_comb begin
    status             = '0;
    status[0]          = empty;
    status[1]          = full;
    status[16 +: CNT_W] = count;
  end

  always_comb begin
    wr_resp = RESP_OKAY;
    case (aw_sel)
      SEL_DATA:   wr_resp = ((w_strb == 4'hF) && !full) ? RESP_OKAY : RESP_SLVERR;
      SEL_STATUS: wr_resp = RESP_SLVERR;
      SEL_CTRL:   wr_resp = RESP_OKAY;
      default:    wr_resp = RESP_DECERR;
    endcase
  end

  // Read of DATA samples the head before any same-edge flush clears pointers.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_sel)
      SEL_DATA: begin
        if (!empty) rd_data = mem[rptr];
        else        rd_resp = RESP_SLVERR;
      end
      SEL_STATUS: rd_data = status;
      SEL_CTRL:   rd_data = '0;
      default:    rd_resp = RESP_DECERR;
    endcase
  end

  // write path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      aw_sel  <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        aw_sel  <= awaddr[3:2];
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      // readies are low while holding, so capture and execute never collide
      if (wr_exec) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_resp;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // read path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_held <= 1'b0;
      ar_sel  <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      if (arvalid && arready) begin
        ar_held <= 1'b1;
        ar_sel  <= araddr[3:2];
      end
      if (rd_exec) begin
        ar_held <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= rd_data;
        rresp   <= rd_resp;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (do_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // storage is not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= w_data;
  end

endmodule

// File: tb/tb_axi_lite_fifo_slave.sv
module tb_axi_lite_fifo_slave;
  import axi_lite_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 50;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  addr_t awaddr = '0;
  prot_t awprot = '0;
  logic  awvalid = 1'b0, awready;
  data_t wdata = '0;
  strb_t wstrb = '0;
  logic  wvalid = 1'b0, wready;
  resp_t bresp;
  logic  bvalid, bready = 1'b1;
  addr_t araddr = '0;
  prot_t arprot = '0;
  logic  arvalid = 1'b0, arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid, rready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  data_t mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_lite_fifo_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // random upper/lower address bits around the decoded [3:2]
  function automatic addr_t mk(input logic [1:0] sel);
    addr_t a;
    a = $urandom();
    a[3:2] = sel;
    return a;
  endfunction

  function automatic data_t model_status();
    data_t s;
    s = 32'(mq.size()) << 16;
    if (mq.size() == DEPTH) s[1] = 1'b1;
    if (mq.size() == 0)     s[0] = 1'b1;
    return s;
  endfunction

  // Issues AW after aw_dly cycles and W after w_dly cycles, then waits for B.
  // Checks that bvalid appears one edge after the later address/data handshake.
  task automatic wr(input addr_t a, input data_t d, input strb_t s,
                    input int aw_dly, input int w_dly, output resp_t resp);
    int  n, aw_e, w_e, last;
    bit  a_ok, w_ok, ha, hw, got;
    n = 0; a_ok = 0; w_ok = 0; aw_e = 0; w_e = 0; got = 0; resp = '0;
    while (!(a_ok && w_ok) && n < TMO) begin
      if (!a_ok && n >= aw_dly) begin awaddr = a; awvalid = 1'b1; end
      if (!w_ok && n >= w_dly)  begin wdata = d; wstrb = s; wvalid = 1'b1; end
      @(negedge clk);
      ha = awvalid && awready;
      hw = wvalid && wready;
      if (ha) aw_e = cyc + 1;
      if (hw) w_e  = cyc + 1;
      @(posedge clk); #1;
      if (ha) begin awvalid = 1'b0; a_ok = 1; end
      if (hw) begin wvalid = 1'b0; w_ok = 1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_accept", 32'(a_ok && w_ok), 32'd1);
    last = (aw_e > w_e) ? aw_e : w_e;
    n = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      if (bvalid) begin
        got = 1;
        resp = bresp;
        chk("wr_latency", 32'(cyc - last), 32'd1);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("bvalid_seen", 32'(got), 32'd1);
  endtask

  task automatic rd(input addr_t a, output data_t d, output resp_t resp);
    int n, ar_e;
    bit ok, ha, got;
    n = 0; ok = 0; got = 0; ar_e = 0; d = '0; resp = '0;
    araddr = a; arvalid = 1'b1;
    while (!ok && n < TMO) begin
      @(negedge clk);
      ha = arvalid && arready;
      if (ha) ar_e = cyc + 1;
      @(posedge clk); #1;
      if (ha) begin arvalid = 1'b0; ok = 1; end
      n++;
    end
    arvalid = 1'b0;
    chk("rd_accept", 32'(ok), 32'd1);
    n = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      if (rvalid) begin
        got = 1;
        d = rdata;
        resp = rresp;
        chk("rd_latency", 32'(cyc - ar_e), 32'd1);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("rvalid_seen", 32'(got), 32'd1);
  endtask

  initial begin
    resp_t r, r1, r2;
    data_t d, d2, dv, e;
    strb_t s;
    int    op;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd(mk(2'd1), d, r);
    chk("status_after_reset", d, 32'h0000_0001);
    chk("status_after_reset_resp", 32'(r), 32'(RESP_OKAY));

    // ---- fill to full, overflow, drain, underflow
    for (int i = 0; i < DEPTH; i++) begin
      dv = 32'hA0 + 32'(i);
      wr(mk(2'd0), dv, 4'hF, 0, 0, r);
      chk("fill_resp", 32'(r), 32'(RESP_OKAY));
      mq.push_back(dv);
    end
    rd(mk(2'd1), d, r);
    chk("status_full", d, 32'h0010_0002);
    chk("status_full_model", d, model_status());
    wr(mk(2'd0), 32'hDEAD, 4'hF, 0, 0, r);
    chk("overflow_resp", 32'(r), 32'(RESP_SLVERR));
    rd(mk(2'd1), d, r);
    chk("status_after_overflow", d, 32'h0010_0002);
    for (int i = 0; i < DEPTH; i++) begin
      rd(mk(2'd0), d, r);
      e = mq.pop_front();
      chk("drain_data", d, e);
      chk("drain_resp", 32'(r), 32'(RESP_OKAY));
    end
    rd(mk(2'd0), d, r);
    chk("underflow_data", d, 32'h0);
    chk("underflow_resp", 32'(r), 32'(RESP_SLVERR));

    // ---- W leading AW by 3 cycles, partial then full strobes
    wr(mk(2'd0), 32'h1234, 4'h3, 3, 0, r);
    chk("partial_strb_resp", 32'(r), 32'(RESP_SLVERR));
    rd(mk(2'd1), d, r);
    chk("partial_strb_no_push", d, 32'h0000_0001);
    wr(mk(2'd0), 32'h5678, 4'hF, 3, 0, r);
    chk("w_lead_full_resp", 32'(r), 32'(RESP_OKAY));
    mq.push_back(32'h5678);

    // ---- flush, STATUS write, unmapped, CTRL read
    for (int i = 0; i < 2; i++) begin
      wr(mk(2'd0), 32'h100 + 32'(i), 4'hF, i, 1 - i, r);
      chk("pre_flush_push", 32'(r), 32'(RESP_OKAY));
      mq.push_back(32'h100 + 32'(i));
    end
    rd(mk(2'd1), d, r);
    chk("status_three", d, model_status());
    wr(mk(2'd2), 32'h1, 4'hF, 0, 0, r);
    chk("flush_resp", 32'(r), 32'(RESP_OKAY));
    mq.delete();
    rd(mk(2'd1), d, r);
    chk("status_after_flush", d, 32'h0000_0001);
    wr(mk(2'd1), 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    chk("status_write_resp", 32'(r), 32'(RESP_SLVERR));
    wr(32'h0000_000C, 32'h42, 4'hF, 0, 0, r);
    chk("unmapped_wr_resp", 32'(r), 32'(RESP_DECERR));
    rd(32'h0000_000C, d, r);
    chk("unmapped_rd_resp", 32'(r), 32'(RESP_DECERR));
    chk("unmapped_rd_data", d, 32'h0);
    rd(mk(2'd2), d, r);
    chk("ctrl_rd_data", d, 32'h0);
    chk("ctrl_rd_resp", 32'(r), 32'(RESP_OKAY));

    // ---- push and pop executing on the same edge
    wr(mk(2'd0), 32'h55, 4'hF, 0, 0, r);
    mq.push_back(32'h55);
    fork
      wr(mk(2'd0), 32'h66, 4'hF, 0, 0, r1);
      rd(mk(2'd0), d2, r2);
    join
    chk("same_edge_rd_data", d2, 32'h55);
    chk("same_edge_rd_resp", 32'(r2), 32'(RESP_OKAY));
    chk("same_edge_wr_resp", 32'(r1), 32'(RESP_OKAY));
    void'(mq.pop_front());
    mq.push_back(32'h66);
    rd(mk(2'd1), d, r);
    chk("same_edge_count", d, 32'h0001_0000);
    rd(mk(2'd0), d, r);
    chk("same_edge_next", d, 32'h66);
    void'(mq.pop_front());

    // ---- randomized traffic against the queue model
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 9);
      dv = $urandom();
      s  = ($urandom_range(0, 4) == 0) ? strb_t'($urandom()) : 4'hF;
      case (op)
        0, 1, 2, 3: begin
          wr(mk(2'd0), dv, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
          if (s == 4'hF && mq.size() < DEPTH) begin
            chk("rnd_push_resp", 32'(r), 32'(RESP_OKAY));
            mq.push_back(dv);
          end else begin
            chk("rnd_push_reject", 32'(r), 32'(RESP_SLVERR));
          end
        end
        4, 5, 6: begin
          rd(mk(2'd0), d, r);
          if (mq.size() > 0) begin
            e = mq.pop_front();
            chk("rnd_pop_data", d, e);
            chk("rnd_pop_resp", 32'(r), 32'(RESP_OKAY));
          end else begin
            chk("rnd_pop_empty_data", d, 32'h0);
            chk("rnd_pop_empty_resp", 32'(r), 32'(RESP_SLVERR));
          end
        end
        7: begin
          rd(mk(2'd1), d, r);
          chk("rnd_status", d, model_status());
          chk("rnd_status_resp", 32'(r), 32'(RESP_OKAY));
        end
        8: begin
          dv[0] = ($urandom_range(0, 3) == 0);
          wr(mk(2'd2), dv, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
          chk("rnd_ctrl_resp", 32'(r), 32'(RESP_OKAY));
          if (dv[0] && s[0]) mq.delete();
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            rd(mk(2'd3), d, r);
            chk("rnd_unmapped_rd", 32'(r), 32'(RESP_DECERR));
            chk("rnd_unmapped_rd_data", d, 32'h0);
          end else begin
            wr(mk(2'd3), dv, s, 0, 0, r);
            chk("rnd_unmapped_wr", 32'(r), 32'(RESP_DECERR));
          end
        end
      endcase
    end

    // ---- B backpressure, then reset while the response is pending
    bready = 1'b0;
    wr(mk(2'd0), 32'h77, 4'hF, 0, 0, r);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bvalid",  32'(bvalid),  32'd1);
      chk("bp_bresp",   32'(bresp),   32'(r));
      chk("bp_awready", 32'(awready), 32'd0);
      chk("bp_wready",  32'(wready),  32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_bvalid",  32'(bvalid),  32'd0);
    chk("rst_mid_awready", 32'(awready), 32'd1);
    mq.delete();
    bready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(mk(2'd1), d, r);
    chk("status_after_mid_reset", d, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
